hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32 core. Each cycle it decides whether the PC and IF/ID register advance, hold or flush, and when the decode stage injects a bubble through `CtrlSignalFlush`. It handles load-use stalls, EX-resolved redirects with a configurable flush window, and memory-wait freezes. It sits beside the decode stage, taking register addresses from IF/ID and destination/load info from ID/EX.

## Interface
Parameters:
- FLUSH_CYCLES, 1, IF/ID flush cycles per redirect; legal range 1..4.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- id_rs1_addr  in  5  rs1 field of the instruction in IF/ID
- id_rs2_addr  in  5  rs2 field of the instruction in IF/ID
- ex_rd_addr  in  5  rd of the instruction in ID/EX
- ex_mem_read  in  1  instruction in ID/EX is a load
- ex_branch_taken  in  1  EX resolved a taken branch or jump this cycle
- im_stall  in  1  instruction memory wait, level
- dm_stall  in  1  data memory wait, level
- pc_write  out  1  PC may update
- ifid_write  out  1  IF/ID may capture
- ifid_flush  out  1  IF/ID loads a NOP
- ctrl_signal_flush  out  1  decode stage zeroes MemRead/MemWrite/RegWrite/branch
- pipe_hold  out  1  ID/EX, EX/MEM and MEM/WB hold their contents
- stall_cnt, flush_cnt, lu_cnt  out  32 each  performance counters (see Configuration)

## Operation
- States: RUN, FLUSH, FREEZE. A 2-bit flush counter `fcnt` belongs to FLUSH.
- Event priority, highest first: freeze (im_stall|dm_stall), redirect (ex_branch_taken), load-use.
- Load-use condition: ex_mem_read & ex_rd_addr!=0 & (ex_rd_addr==id_rs1_addr | ex_rd_addr==id_rs2_addr). The rs2 compare is always made; a false stall is acceptable.
- RUN:
  - Freeze: pipe_hold=1, pc_write=0, ifid_write=0, no flush. Next state FREEZE.
  - Redirect: pc_write=1, ifid_flush=1, ctrl_signal_flush=1. If FLUSH_CYCLES>1, next state FLUSH with fcnt=FLUSH_CYCLES-1; otherwise stay in RUN.
  - Load-use: pc_write=0, ifid_write=0, ctrl_signal_flush=1 (one bubble). Stay in RUN.
  - No event: pc_write=1, ifid_write=1, all other outputs 0.
- FLUSH:
  - pc_write=1, ifid_flush=1, ctrl_signal_flush=1.
  - fcnt decrements each cycle; go to RUN when fcnt reaches 1.
  - Load-use is ignored in FLUSH.
  - A new ex_branch_taken reloads fcnt=FLUSH_CYCLES-1.
  - A freeze goes to FREEZE and abandons the remaining flush; wrong-path bubbles are already squashed.
- FREEZE: pipe_hold=1, pc_write=0, ifid_write=0, flushes 0. Go to RUN on the first cycle both stalls are low. EX inputs are frozen, so a pending redirect or load-use is re-evaluated in RUN with no latch.

## Timing
- Outputs are combinational from the state register and the current inputs, so they act in the same cycle as the event. State and counters are registered on posedge clk.
- While rst=0: state=RUN, fcnt=0, counters=0. Outputs then decode as RUN: pc_write=1, ifid_write=1, everything else 0.
- A reset asserted mid-FLUSH or mid-FREEZE returns to RUN immediately, asynchronously.
- Redirect timing: ifid_flush is high for exactly FLUSH_CYCLES consecutive cycles, starting in the cycle of ex_branch_taken.
- Load-use costs exactly one stall cycle. The next cycle ex_mem_read sees the bubble and the pipeline advances.
- Simultaneous freeze and redirect: the freeze wins, and the redirect is taken on the first non-frozen cycle.

## Configuration
- Macro HAZARD_PERF_EN.
- Defined:
  - stall_cnt increments on each freeze or load-use cycle.
  - flush_cnt increments on each redirect event (not per flush cycle).
  - lu_cnt increments on each load-use stall.
  - All three saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: all three ports are tied to 0 and no counter flops exist. The port list is identical either way.

## Structure
- hazard_pkg: state enum (RUN/FLUSH/FREEZE), FLUSH_CYCLES default, FCNT_W=2.
- Sub-module hazard_perf_counter: 32-bit saturating counter with an increment enable, instantiated three times under HAZARD_PERF_EN.

## Test plan
- Reset: hold rst=0 with im_stall=1 -> pc_write=1, ifid_write=1, pipe_hold=0. Release -> FREEZE on the next edge.
- Load-use: ex_mem_read=1, ex_rd_addr=5, id_rs2_addr=5 -> one cycle of pc_write=0, ifid_write=0, ctrl_signal_flush=1. Same case with ex_rd_addr=0 -> no stall.
- Redirect: FLUSH_CYCLES=3, pulse ex_branch_taken -> ifid_flush high for exactly 3 cycles, pc_write=1 throughout, flush_cnt=1.
- Freeze during FLUSH: FLUSH_CYCLES=3, dm_stall=1 in the second flush cycle for 4 cycles -> pipe_hold=1 for 4 cycles, no further ifid_flush, RUN afterwards.
- Priority: ex_branch_taken=1 with im_stall=1 for 2 cycles -> freeze for 2 cycles, then one flush cycle (FLUSH_CYCLES=1).
- Counters (HAZARD_PERF_EN, force stall_cnt to 32'hFFFF_FFFE) -> after 3 stall cycles reads 32'hFFFF_FFFF. Same stimulus without the macro -> all counters read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  localparam int FLUSH_CYCLES_DEF = 1;
  localparam int FCNT_W           = 2;
  localparam int CNT_W            = 32;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    FREEZE = 2'd2
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle; master is the core pipeline, slave is hazard_ctrl.
interface hazard_ctrl_if;
  import hazard_pkg::*;

  logic [4:0]       id_rs1_addr;
  logic [4:0]       id_rs2_addr;
  logic [4:0]       ex_rd_addr;
  logic             ex_mem_read;
  logic             ex_branch_taken;
  logic             im_stall;
  logic             dm_stall;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             ctrl_signal_flush;
  logic             pipe_hold;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] lu_cnt;

  modport master (
    output id_rs1_addr, id_rs2_addr, ex_rd_addr, ex_mem_read, ex_branch_taken,
           im_stall, dm_stall,
    input  pc_write, ifid_write, ifid_flush, ctrl_signal_flush, pipe_hold,
           stall_cnt, flush_cnt, lu_cnt
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr, ex_rd_addr, ex_mem_read, ex_branch_taken,
           im_stall, dm_stall,
    output pc_write, ifid_write, ifid_flush, ctrl_signal_flush, pipe_hold,
           stall_cnt, flush_cnt, lu_cnt
  );

endinterface

// File: rtl/hazard_perf_counter.sv
// 32-bit saturating event counter with increment enable, cleared by reset.
module hazard_perf_counter
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: freeze > redirect > load-use; outputs combinational from state + inputs.
// Performance counters are built only when HAZARD_PERF_EN is defined; otherwise they read 0.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);

  localparam logic [FCNT_W-1:0] FCNT_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);
  localparam bit                MULTI_FLUSH = (FLUSH_CYCLES > 1);

  hz_state_e         state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              freeze_ev, redir_ev, lu_ev, in_flush;
  logic              hold_act, flush_act, lu_act;

  // Events are masked during reset so the outputs decode as idle RUN.
  assign freeze_ev = rst & (hz.im_stall | hz.dm_stall);
  assign redir_ev  = rst & hz.ex_branch_taken;
  assign lu_ev     = rst & hz.ex_mem_read & (hz.ex_rd_addr != 5'd0) &
                     ((hz.ex_rd_addr == hz.id_rs1_addr) | (hz.ex_rd_addr == hz.id_rs2_addr));
  assign in_flush  = (state_q == FLUSH);

  assign hold_act  = freeze_ev;
  assign flush_act = !freeze_ev & (redir_ev | in_flush);
  assign lu_act    = !freeze_ev & !redir_ev & !in_flush & lu_ev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // FREEZE with both stalls low behaves exactly like RUN, so a held redirect acts at once.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (freeze_ev) begin
      state_d = FREEZE;
      fcnt_d  = '0;
    end else if (redir_ev) begin
      if (MULTI_FLUSH) begin
        state_d = FLUSH;
        fcnt_d  = FCNT_RELOAD;
      end else begin
        state_d = RUN;
        fcnt_d  = '0;
      end
    end else begin
      case (state_q)
        FLUSH: begin
          if (fcnt_q <= FCNT_W'(1)) begin
            state_d = RUN;
            fcnt_d  = '0;
          end else begin
            fcnt_d = fcnt_q - FCNT_W'(1);
          end
        end
        default: begin
          state_d = RUN;
          fcnt_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    hz.pc_write          = 1'b1;
    hz.ifid_write        = 1'b1;
    hz.ifid_flush        = 1'b0;
    hz.ctrl_signal_flush = 1'b0;
    hz.pipe_hold         = 1'b0;
    if (hold_act) begin
      hz.pipe_hold  = 1'b1;
      hz.pc_write   = 1'b0;
      hz.ifid_write = 1'b0;
    end else if (flush_act) begin
      hz.ifid_flush        = 1'b1;
      hz.ctrl_signal_flush = 1'b1;
    end else if (lu_act) begin
      hz.pc_write          = 1'b0;
      hz.ifid_write        = 1'b0;
      hz.ctrl_signal_flush = 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  logic redir_act;
  assign redir_act = !freeze_ev & redir_ev;

  hazard_perf_counter u_stall_cnt (.clk(clk), .rst(rst), .inc_i(hold_act | lu_act), .cnt_o(hz.stall_cnt));
  hazard_perf_counter u_flush_cnt (.clk(clk), .rst(rst), .inc_i(redir_act),         .cnt_o(hz.flush_cnt));
  hazard_perf_counter u_lu_cnt    (.clk(clk), .rst(rst), .inc_i(lu_act),            .cnt_o(hz.lu_cnt));
`else
  assign hz.stall_cnt = '0;
  assign hz.flush_cnt = '0;
  assign hz.lu_cnt    = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench: two controllers (FLUSH_CYCLES=3 and =1) driven with the same pipeline inputs.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       im = 1'b0, dm = 1'b0, br = 1'b0, mr = 1'b0;
  logic [4:0] rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if b3 ();
  hazard_ctrl_if b1 ();

  assign b3.im_stall = im;        assign b1.im_stall = im;
  assign b3.dm_stall = dm;        assign b1.dm_stall = dm;
  assign b3.ex_branch_taken = br; assign b1.ex_branch_taken = br;
  assign b3.ex_mem_read = mr;     assign b1.ex_mem_read = mr;
  assign b3.ex_rd_addr = rd;      assign b1.ex_rd_addr = rd;
  assign b3.id_rs1_addr = rs1;    assign b1.id_rs1_addr = rs1;
  assign b3.id_rs2_addr = rs2;    assign b1.id_rs2_addr = rs2;

  hazard_ctrl #(.FLUSH_CYCLES(3)) u3 (.clk(clk), .rst(rst), .hz(b3));
  hazard_ctrl #(.FLUSH_CYCLES(1)) u1 (.clk(clk), .rst(rst), .hz(b1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs on the falling edge, then settle before checking.
  task automatic step(input logic r, input logic i_im, input logic i_dm, input logic i_br,
                      input logic i_mr, input logic [4:0] i_rd, input logic [4:0] i_rs1,
                      input logic [4:0] i_rs2);
    @(negedge clk);
    rst = r; im = i_im; dm = i_dm; br = i_br; mr = i_mr;
    rd = i_rd; rs1 = i_rs1; rs2 = i_rs2;
    #1;
  endtask

  initial begin
    // Reset held with a pending instruction-memory stall
    step(0, 1, 0, 0, 0, 0, 0, 0);
    chk("rst_pc_write", 32'(b3.pc_write), 1);
    chk("rst_ifid_write", 32'(b3.ifid_write), 1);
    chk("rst_pipe_hold", 32'(b3.pipe_hold), 0);
    chk("rst_stall_cnt", b3.stall_cnt, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    chk("rst_hold2", 32'(b3.pipe_hold), 0);
    chk("rst_state", 32'(u3.state_q), 32'(RUN));

    step(1, 1, 0, 0, 0, 0, 0, 0);
    chk("rel_pipe_hold", 32'(b3.pipe_hold), 1);
    chk("rel_pc_write", 32'(b3.pc_write), 0);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    chk("rel_state_freeze", 32'(u3.state_q), 32'(FREEZE));
    chk("rel_ifid_write", 32'(b3.ifid_write), 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("unfreeze_pc_write", 32'(b3.pc_write), 1);
    chk("unfreeze_hold", 32'(b3.pipe_hold), 0);

    // Load-use on rs2, then the bubble
    step(1, 0, 0, 0, 1, 5, 1, 5);
    chk("lu_pc_write", 32'(b3.pc_write), 0);
    chk("lu_ifid_write", 32'(b3.ifid_write), 0);
    chk("lu_ctrl_flush", 32'(b3.ctrl_signal_flush), 1);
    chk("lu_ifid_flush", 32'(b3.ifid_flush), 0);
    step(1, 0, 0, 0, 0, 5, 1, 5);
    chk("lu_bubble_pc_write", 32'(b3.pc_write), 1);
    chk("lu_bubble_ctrl", 32'(b3.ctrl_signal_flush), 0);
    step(1, 0, 0, 0, 1, 0, 0, 0);
    chk("lu_x0_pc_write", 32'(b3.pc_write), 1);
    chk("lu_x0_ctrl", 32'(b3.ctrl_signal_flush), 0);
    step(1, 0, 0, 0, 1, 7, 7, 3);
    chk("lu_rs1_pc_write", 32'(b3.pc_write), 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);

    // Redirect, FLUSH_CYCLES=3; load-use ignored while flushing
    step(1, 0, 0, 1, 0, 0, 0, 0);
    chk("rd_f1_ifid_flush", 32'(b3.ifid_flush), 1);
    chk("rd_f1_pc_write", 32'(b3.pc_write), 1);
    chk("rd_f1_ctrl", 32'(b3.ctrl_signal_flush), 1);
    step(1, 0, 0, 0, 1, 5, 1, 5);
    chk("rd_f2_ifid_flush", 32'(b3.ifid_flush), 1);
    chk("rd_f2_pc_write", 32'(b3.pc_write), 1);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rd_f3_ifid_flush", 32'(b3.ifid_flush), 1);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rd_end_ifid_flush", 32'(b3.ifid_flush), 0);
    chk("rd_end_pc_write", 32'(b3.pc_write), 1);
`ifdef HAZARD_PERF_EN
    chk("rd_flush_cnt", b3.flush_cnt, 1);
`else
    chk("rd_flush_cnt", b3.flush_cnt, 0);
`endif

    // Freeze in the second flush cycle for 4 cycles
    step(1, 0, 0, 1, 0, 0, 0, 0);
    chk("fz_f1_ifid_flush", 32'(b3.ifid_flush), 1);
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 1, 0, 0, 0, 0, 0);
      chk("fz_pipe_hold", 32'(b3.pipe_hold), 1);
      chk("fz_ifid_flush", 32'(b3.ifid_flush), 0);
    end
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("fz_after_hold", 32'(b3.pipe_hold), 0);
    chk("fz_after_ifid_flush", 32'(b3.ifid_flush), 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("fz_after_state", 32'(u3.state_q), 32'(RUN));
    chk("fz_after_ifid_flush2", 32'(b3.ifid_flush), 0);

    // Freeze beats redirect, FLUSH_CYCLES=1
    step(1, 1, 0, 1, 0, 0, 0, 0);
    chk("pri_c1_hold", 32'(b1.pipe_hold), 1);
    chk("pri_c1_ifid_flush", 32'(b1.ifid_flush), 0);
    step(1, 1, 0, 1, 0, 0, 0, 0);
    chk("pri_c2_hold", 32'(b1.pipe_hold), 1);
    step(1, 0, 0, 1, 0, 0, 0, 0);
    chk("pri_c3_ifid_flush", 32'(b1.ifid_flush), 1);
    chk("pri_c3_hold", 32'(b1.pipe_hold), 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("pri_c4_ifid_flush", 32'(b1.ifid_flush), 0);
    chk("pri_c4_fc3_still_flush", 32'(b3.ifid_flush), 1);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("pri_fc3_done", 32'(b3.ifid_flush), 0);
`ifdef HAZARD_PERF_EN
    chk("cnt_stall", b3.stall_cnt, 10);
    chk("cnt_flush", b3.flush_cnt, 3);
    chk("cnt_lu", b3.lu_cnt, 2);
`else
    chk("cnt_stall", b3.stall_cnt, 0);
    chk("cnt_lu", b3.lu_cnt, 0);
`endif

    // Asynchronous reset in the middle of a flush
    step(1, 0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("mid_flush_pre", 32'(b3.ifid_flush), 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_state", 32'(u3.state_q), 32'(RUN));
    chk("mid_rst_ifid_flush", 32'(b3.ifid_flush), 0);
    chk("mid_rst_pc_write", 32'(b3.pc_write), 1);
    chk("mid_rst_flush_cnt", b3.flush_cnt, 0);

    // Saturation of the stall counter
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("sat_pre_stall", b3.stall_cnt, 0);
`ifdef HAZARD_PERF_EN
    force u3.u_stall_cnt.cnt_q = 32'hFFFF_FFFE;
    #1;
    release u3.u_stall_cnt.cnt_q;
`endif
    for (int k = 0; k < 3; k++) step(1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
`ifdef HAZARD_PERF_EN
    chk("sat_stall_cnt", b3.stall_cnt, 32'hFFFF_FFFF);
`else
    chk("sat_stall_cnt", b3.stall_cnt, 0);
    chk("sat_flush_cnt", b3.flush_cnt, 0);
`endif
    chk("sat_lu_cnt", b3.lu_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
